// File: rtl/frontend_response_returner_if.sv
// rtl/frontend_response_returner_if.sv - request tag, backend read-data and response bundle
// master drives requests, read beats and resp_ready; slave is the returner.
interface frontend_response_returner_if #(
  parameter int DATA_WIDTH = 128
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_op_type;
  logic [4:0]            req_id;
  logic [1:0]            req_core_num;
  logic                  rd_data_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  resp_valid;
  logic                  resp_ready;
  logic                  resp_op_type;
  logic [4:0]            resp_req_id;
  logic [1:0]            resp_core_num;
  logic [DATA_WIDTH-1:0] resp_data;

  modport master (
    output req_valid, req_op_type, req_id, req_core_num,
    output rd_data_valid, rd_data, resp_ready,
    input  req_ready, resp_valid, resp_op_type, resp_req_id, resp_core_num, resp_data
  );

  modport slave (
    input  req_valid, req_op_type, req_id, req_core_num,
    input  rd_data_valid, rd_data, resp_ready,
    output req_ready, resp_valid, resp_op_type, resp_req_id, resp_core_num, resp_data
  );
endinterface

// File: rtl/frontend_response_returner.sv
// rtl/frontend_response_returner.sv - in-order tagged response return path
// Tags queue in arrival order; READ tags pair with buffered backend beats, WRITE tags ack with zero data.
module frontend_response_returner #(
  parameter int TAG_DEPTH  = 8,
  parameter int DATA_DEPTH = 4,
  parameter int DATA_WIDTH = 128
) (
  input  logic                        clk,
  input  logic                        rst_n,
  frontend_response_returner_if.slave bus,
  output logic [$clog2(TAG_DEPTH):0]  outstanding_cnt,
  output logic                        err_overflow,
  output logic                        err_orphan
);
  localparam int TAW = $clog2(TAG_DEPTH);
  localparam int DAW = $clog2(DATA_DEPTH);
  localparam logic [TAW:0] TAG_ONE = {{TAW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_WAIT_DATA, S_RESP} state_t;
  typedef struct packed {
    logic       op;
    logic [4:0] id;
    logic [1:0] core;
  } tag_t;

  state_t                state_q, state_d;
  logic [TAW:0]          tag_wr_ptr_q, tag_wr_ptr_d, tag_rd_ptr_q, tag_rd_ptr_d;
  logic [TAW:0]          pending_q, pending_d;
  logic [DAW:0]          dat_wr_ptr_q, dat_wr_ptr_d, dat_rd_ptr_q, dat_rd_ptr_d;
  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  tag_t                  resp_tag_q, resp_tag_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                  err_overflow_q, err_overflow_d, err_orphan_q, err_orphan_d;

  tag_t                  tag_mem [TAG_DEPTH];
  logic [DATA_WIDTH-1:0] dat_mem [DATA_DEPTH];

  logic                  tag_push, tag_pop, beat_push, dat_pop, dat_full, read_push;
  logic                  load, eval_head;
  logic [TAW:0]          tag_cnt, eff_tag_cnt, head_ptr;
  logic [DAW:0]          dat_cnt, eff_dat_cnt, dat_head_ptr;
  tag_t                  head_tag;

  assign tag_push  = bus.req_valid && req_ready_q;
  assign read_push = tag_push && bus.req_op_type;
  assign tag_pop   = resp_valid_q && bus.resp_ready;
  assign dat_pop   = tag_pop && resp_tag_q.op;
  assign tag_cnt   = tag_wr_ptr_q - tag_rd_ptr_q;
  assign dat_cnt   = dat_wr_ptr_q - dat_rd_ptr_q;
  assign dat_full  = (dat_wr_ptr_q[DAW] != dat_rd_ptr_q[DAW]) &&
                     (dat_wr_ptr_q[DAW-1:0] == dat_rd_ptr_q[DAW-1:0]);
  assign beat_push = bus.rd_data_valid && !dat_full && (pending_q != '0);

  // After a handshake the next head is one entry past the one being popped.
  assign head_ptr     = tag_rd_ptr_q + {{TAW{1'b0}}, tag_pop};
  assign dat_head_ptr = dat_rd_ptr_q + {{DAW{1'b0}}, dat_pop};
  assign eff_tag_cnt  = tag_cnt - {{TAW{1'b0}}, tag_pop};
  assign eff_dat_cnt  = dat_cnt - {{DAW{1'b0}}, dat_pop};
  assign head_tag     = tag_mem[head_ptr[TAW-1:0]];

  always_comb begin
    tag_wr_ptr_d = tag_wr_ptr_q + {{TAW{1'b0}}, tag_push};
    tag_rd_ptr_d = tag_rd_ptr_q + {{TAW{1'b0}}, tag_pop};
    dat_wr_ptr_d = dat_wr_ptr_q + {{DAW{1'b0}}, beat_push};
    dat_rd_ptr_d = dat_rd_ptr_q + {{DAW{1'b0}}, dat_pop};
    pending_d    = pending_q;
    if (read_push && !beat_push) begin
      pending_d = pending_q + TAG_ONE;
    end else if (!read_push && beat_push) begin
      pending_d = pending_q - TAG_ONE;
    end
    req_ready_d    = !((tag_wr_ptr_d[TAW] != tag_rd_ptr_d[TAW]) &&
                       (tag_wr_ptr_d[TAW-1:0] == tag_rd_ptr_d[TAW-1:0]));
    err_overflow_d = err_overflow_q || (bus.rd_data_valid && dat_full);
    err_orphan_d   = err_orphan_q || (bus.rd_data_valid && (pending_q == '0));
  end

  always_comb begin
    state_d      = state_q;
    resp_valid_d = resp_valid_q && !tag_pop;
    resp_tag_d   = resp_tag_q;
    resp_data_d  = resp_data_q;
    load         = 1'b0;
    eval_head    = 1'b0;
    case (state_q)
      S_IDLE:      eval_head = 1'b1;
      S_WAIT_DATA: load = (dat_cnt != '0);
      S_RESP:      eval_head = tag_pop;
      default:     state_d = S_IDLE;
    endcase
    if (eval_head) begin
      state_d = S_IDLE;
      if (eff_tag_cnt != '0) begin
        if (!head_tag.op || (eff_dat_cnt != '0)) begin
          load = 1'b1;
        end else begin
          state_d = S_WAIT_DATA;
        end
      end
    end
    if (load) begin
      state_d      = S_RESP;
      resp_valid_d = 1'b1;
      resp_tag_d   = head_tag;
      resp_data_d  = head_tag.op ? dat_mem[dat_head_ptr[DAW-1:0]] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_push) begin
      tag_mem[tag_wr_ptr_q[TAW-1:0]] <= '{op: bus.req_op_type, id: bus.req_id, core: bus.req_core_num};
    end
    if (beat_push) begin
      dat_mem[dat_wr_ptr_q[DAW-1:0]] <= bus.rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      tag_wr_ptr_q   <= '0;
      tag_rd_ptr_q   <= '0;
      dat_wr_ptr_q   <= '0;
      dat_rd_ptr_q   <= '0;
      pending_q      <= '0;
      req_ready_q    <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_tag_q     <= '0;
      resp_data_q    <= '0;
      err_overflow_q <= 1'b0;
      err_orphan_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      tag_wr_ptr_q   <= tag_wr_ptr_d;
      tag_rd_ptr_q   <= tag_rd_ptr_d;
      dat_wr_ptr_q   <= dat_wr_ptr_d;
      dat_rd_ptr_q   <= dat_rd_ptr_d;
      pending_q      <= pending_d;
      req_ready_q    <= req_ready_d;
      resp_valid_q   <= resp_valid_d;
      resp_tag_q     <= resp_tag_d;
      resp_data_q    <= resp_data_d;
      err_overflow_q <= err_overflow_d;
      err_orphan_q   <= err_orphan_d;
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_op_type  = resp_tag_q.op;
  assign bus.resp_req_id   = resp_tag_q.id;
  assign bus.resp_core_num = resp_tag_q.core;
  assign bus.resp_data     = resp_data_q;
  assign outstanding_cnt   = tag_cnt;
  assign err_overflow      = err_overflow_q;
  assign err_orphan        = err_orphan_q;
endmodule

// File: tb/tb_frontend_response_returner.sv
// tb/tb_frontend_response_returner.sv - randomized bench against a queue-based response model
module tb_frontend_response_returner;
  localparam int DW   = 128;
  localparam int TAGD = 8;
  localparam int DATD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] outstanding_cnt;
  logic       err_overflow;
  logic       err_orphan;

  frontend_response_returner_if #(.DATA_WIDTH(DW)) bus ();

  frontend_response_returner #(
    .TAG_DEPTH(TAGD), .DATA_DEPTH(DATD), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .outstanding_cnt(outstanding_cnt), .err_overflow(err_overflow), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       op;
    logic [4:0] id;
    logic [1:0] core;
  } tag_t;

  tag_t         tq[$];
  logic [DW-1:0] dq[$];
  logic [4:0]   popped[$];
  int           pending, n_vec, n_err, wait_cnt;
  logic         exp_ready, exp_ovf, exp_orph, prev_stall;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    tq.delete();
    dq.delete();
    pending    = 0;
    exp_ready  = 1'b0;
    exp_ovf    = 1'b0;
    exp_orph   = 1'b0;
    wait_cnt   = 0;
    prev_stall = 1'b0;
  endtask

  task automatic check_reset_zero();
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_fields", {bus.resp_op_type, bus.resp_req_id, bus.resp_core_num}, 0);
    chk("rst_resp_data", bus.resp_data, 0);
    chk("rst_outstanding", outstanding_cnt, 0);
    chk("rst_errs", {err_overflow, err_orphan}, 0);
  endtask

  task automatic check_outputs();
    logic avail;
    chk("req_ready", bus.req_ready, exp_ready);
    chk("outstanding", outstanding_cnt, tq.size());
    chk("err_overflow", err_overflow, exp_ovf);
    chk("err_orphan", err_orphan, exp_orph);
    if (prev_stall) chk("resp_hold", bus.resp_valid, 1);
    if (bus.resp_valid) begin
      if (tq.size() == 0) begin
        chk("resp_spurious", 1, 0);
      end else begin
        chk("resp_op", bus.resp_op_type, tq[0].op);
        chk("resp_id", bus.resp_req_id, tq[0].id);
        chk("resp_core", bus.resp_core_num, tq[0].core);
        if (!tq[0].op) chk("resp_data_wr", bus.resp_data, 0);
        else if (dq.size() == 0) chk("resp_nodata", 1, 0);
        else chk("resp_data_rd", bus.resp_data, dq[0]);
      end
    end
    avail = (tq.size() > 0) && (!tq[0].op || dq.size() > 0);
    if (avail && !bus.resp_valid) wait_cnt++;
    else wait_cnt = 0;
    if (wait_cnt > 0) chk("resp_latency", wait_cnt <= 1, 1);
  endtask

  // One clock: check outputs, apply inputs, advance the model at the edge.
  task automatic step(input logic v, input logic op, input logic [4:0] id, input logic [1:0] core,
                      input logic bv, input logic [DW-1:0] bd, input logic rr);
    logic       push, pop;
    logic [4:0] pid;
    tag_t       t;
    check_outputs();
    bus.req_valid     = v;
    bus.req_op_type   = op;
    bus.req_id        = id;
    bus.req_core_num  = core;
    bus.rd_data_valid = bv;
    bus.rd_data       = bd;
    bus.resp_ready    = rr;
    push       = v && exp_ready;
    pop        = bus.resp_valid && rr;
    pid        = bus.resp_req_id;
    prev_stall = bus.resp_valid && !rr;
    @(posedge clk);
    if (bv) begin
      if (dq.size() == DATD) exp_ovf = 1'b1;
      if (pending == 0) exp_orph = 1'b1;
      if (dq.size() < DATD && pending > 0) begin
        dq.push_back(bd);
        pending--;
      end
    end
    if (push) begin
      t.op = op; t.id = id; t.core = core;
      tq.push_back(t);
      if (op) pending++;
    end
    if (pop && tq.size() > 0) begin
      popped.push_back(pid);
      if (tq[0].op && dq.size() > 0) void'(dq.pop_front());
      void'(tq.pop_front());
    end
    exp_ready = (tq.size() < TAGD);
    @(negedge clk);
    bus.req_valid     = 1'b0;
    bus.rd_data_valid = 1'b0;
  endtask

  task automatic idle(input logic rr);
    step(1'b0, 1'b0, 5'd0, 2'd0, 1'b0, '0, rr);
  endtask

  function automatic logic [DW-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drain();
    int guard = 0;
    while (tq.size() > 0 && guard < 300) begin
      step(1'b0, 1'b0, 5'd0, 2'd0, (pending > 0) && ($urandom_range(0, 1) == 1), rand_data(), 1'b1);
      guard++;
    end
    if (guard >= 300) chk("drain_timeout", 1, 0);
    chk("drain_outstanding", outstanding_cnt, tq.size());
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    bus.req_valid = 0; bus.req_op_type = 0; bus.req_id = 0; bus.req_core_num = 0;
    bus.rd_data_valid = 0; bus.rd_data = '0; bus.resp_ready = 0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_zero();
    rst_n = 1'b1;
    idle(1'b0);
    chk("ready_after_rst", bus.req_ready, 1);

    // Single READ, beat three cycles later
    step(1'b1, 1'b1, 5'd7, 2'd1, 1'b0, '0, 1'b1);
    chk("t1_cnt_one", outstanding_cnt, 1);
    repeat (2) idle(1'b1);
    step(1'b0, 1'b0, 5'd0, 2'd0, 1'b1, 128'hA5, 1'b0);
    chk("t1_lat_before", bus.resp_valid, 0);
    idle(1'b0);
    chk("t1_valid", bus.resp_valid, 1);
    chk("t1_data", bus.resp_data, 128'hA5);
    chk("t1_id", bus.resp_req_id, 7);
    idle(1'b1);
    chk("t1_cnt_zero", outstanding_cnt, 0);

    // WRITE ack two cycles after push
    step(1'b1, 1'b0, 5'd3, 2'd2, 1'b0, '0, 1'b1);
    chk("t2_lat_before", bus.resp_valid, 0);
    idle(1'b1);
    chk("t2_valid", bus.resp_valid, 1);
    chk("t2_data", bus.resp_data, 0);
    chk("t2_core", bus.resp_core_num, 2);
    idle(1'b1);

    // Mixed ordering with toggling resp_ready
    popped.delete();
    step(1'b1, 1'b1, 5'd1, 2'd0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, 5'd2, 2'd1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 5'd3, 2'd3, 1'b1, 128'hD1, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 5'd0, 2'd0, i == 5, 128'hD3, (i % 2) == 1);
    chk("t3_count", popped.size(), 3);
    for (int k = 0; k < 3; k++) chk("t3_order", (k < popped.size()) ? popped[k] : 5'h1f, k + 1);

    // Fill the tag FIFO, ninth request ignored, drain
    popped.delete();
    for (int i = 0; i < TAGD; i++) step(1'b1, 1'b0, 5'(i + 8), 2'(i), 1'b0, '0, 1'b0);
    chk("t4_ready_full", bus.req_ready, 0);
    step(1'b1, 1'b0, 5'd31, 2'd3, 1'b0, '0, 1'b0);
    chk("t4_cnt_full", outstanding_cnt, TAGD);
    for (int i = 0; i < 12; i++) idle(1'b1);
    chk("t4_drained", popped.size(), TAGD);

    // Orphan beat, then overflow on the fifth beat
    step(1'b0, 1'b0, 5'd0, 2'd0, 1'b1, 128'hBAD, 1'b1);
    chk("t5_orphan", err_orphan, 1);
    chk("t5_no_resp", bus.resp_valid, 0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 5'(16 + i), 2'(i), 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 5'd0, 2'd0, 1'b1, rand_data(), 1'b0);
    chk("t5_no_ovf_yet", err_overflow, 0);
    step(1'b0, 1'b0, 5'd0, 2'd0, 1'b1, rand_data(), 1'b0);
    chk("t5_overflow", err_overflow, 1);
    drain();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 5'($urandom), 2'($urandom),
           (pending > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0),
           rand_data(), $urandom_range(0, 3) != 0);
    end
    drain();

    // Reset with tags outstanding and a response stalled
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 5'(i), 2'(i), 1'b0, '0, 1'b0);
    chk("t7_stalled", bus.resp_valid, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_zero();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b0);
    repeat (3) idle(1'b1);
    chk("t7_cnt", outstanding_cnt, 0);
    chk("t7_no_resp", bus.resp_valid, 0);
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
